eth_rx_frame_buffer: RTL and testbench

ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

---
 rtl/eth_rx_frame_buffer.sv | 112 +++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward receive buffer for 512-bit MAC beats. A frame becomes readable only once its
// error-free tlast beat is stored; errored or overflowing frames are rewound and counted as drops.
module eth_rx_frame_buffer #(
    parameter int unsigned DEPTH = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         si_tvalid,
    output logic         si_tready,
    input  logic [511:0] si_tdata,
    input  logic [63:0]  si_tkeep,
    input  logic         si_tlast,
    input  logic         si_tuser,
    output logic         frame_q_empty,
    input  logic         frame_q_read,
    output logic [576:0] frame_q_dout,
    output logic [31:0]  drop_count,
    output logic [31:0]  frame_count
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PtrOne = 1;

    typedef enum logic [0:0] {StWrite, StDrop} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W:0]     r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [ADDR_W:0]     w_wr_ptr_nxt, w_commit_ptr_nxt, w_used;
    logic [31:0]         r_drop_count, r_frame_count, w_drop_nxt, w_frame_nxt;
    logic [576:0]        r_mem [DEPTH];
    logic [576:0]        r_dout;
    logic                w_accept, w_full, w_mem_we, w_rd_en;

    assign si_tready     = ~rst;
    assign w_accept      = si_tvalid & si_tready;
    // Occupancy never exceeds DEPTH, so the MSB of the difference alone flags full.
    assign w_used        = r_wr_ptr - r_rd_ptr;
    assign w_full        = w_used[ADDR_W];
    assign frame_q_empty = (r_rd_ptr == r_commit_ptr);
    assign w_rd_en       = frame_q_read & ~frame_q_empty;
    assign frame_q_dout  = r_dout;
    assign drop_count    = r_drop_count;
    assign frame_count   = r_frame_count;

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_drop_nxt       = r_drop_count;
        w_frame_nxt      = r_frame_count;
        w_mem_we         = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                StWrite: begin
                    if (si_tlast && si_tuser) begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_drop_nxt   = r_drop_count + 32'd1;
                    end else if (w_full) begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_drop_nxt   = r_drop_count + 32'd1;
                        if (!si_tlast) begin
                            w_state_nxt = StDrop;
                        end
                    end else begin
                        w_mem_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + PtrOne;
                        if (si_tlast) begin
                            w_commit_ptr_nxt = r_wr_ptr + PtrOne;
                            w_frame_nxt      = r_frame_count + 32'd1;
                        end
                    end
                end
                StDrop: begin
                    if (si_tlast) begin
                        w_state_nxt = StWrite;
                    end
                end
                default: w_state_nxt = StWrite;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StWrite;
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_rd_ptr      <= '0;
            r_drop_count  <= '0;
            r_frame_count <= '0;
            r_dout        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_commit_ptr  <= w_commit_ptr_nxt;
            r_drop_count  <= w_drop_nxt;
            r_frame_count <= w_frame_nxt;
            if (w_rd_en) begin
                r_dout   <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
        end
    end

    // Storage array is left unreset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {si_tlast, si_tkeep, si_tdata};
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: table of frames plus hand-written overflow/reset/empty-read cases,
// with committed beats queued as expectations and popped as the reader drains the buffer.
module tb_eth_rx_frame_buffer;

    localparam int unsigned DEPTH = 16;
    typedef logic [576:0] beat_t;
    typedef struct {
        int   len;
        logic err;
        logic commit;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         si_tvalid, si_tready, si_tlast, si_tuser;
    logic [511:0] si_tdata;
    logic [63:0]  si_tkeep;
    logic         frame_q_empty, frame_q_read;
    logic [576:0] frame_q_dout;
    logic [31:0]  drop_count, frame_count;

    beat_t       sb_q[$];
    beat_t       last_exp;
    int unsigned n_total = 0;
    int unsigned n_bad = 0;
    int unsigned exp_drop = 0;
    int unsigned exp_frame = 0;
    vec_t        vecs[8];

    eth_rx_frame_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .si_tvalid     (si_tvalid),
        .si_tready     (si_tready),
        .si_tdata      (si_tdata),
        .si_tkeep      (si_tkeep),
        .si_tlast      (si_tlast),
        .si_tuser      (si_tuser),
        .frame_q_empty (frame_q_empty),
        .frame_q_read  (frame_q_read),
        .frame_q_dout  (frame_q_dout),
        .drop_count    (drop_count),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input beat_t act, input beat_t exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name);
        check({name, "_drop_count"}, beat_t'(drop_count), beat_t'(exp_drop));
        check({name, "_frame_count"}, beat_t'(frame_count), beat_t'(exp_frame));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_tready"}, beat_t'(si_tready), beat_t'(1'b0));
        check({name, "_empty"}, beat_t'(frame_q_empty), beat_t'(1'b1));
        check({name, "_dout"}, frame_q_dout, '0);
        check({name, "_drop_count"}, beat_t'(drop_count), '0);
        check({name, "_frame_count"}, beat_t'(frame_count), '0);
    endtask

    // chk_sf: buffer is known drained, so empty must stay high until tlast is stored.
    task automatic send_frame(input int len, input logic err, input logic exp_commit,
                              input logic chk_sf);
        beat_t        fr[$];
        logic [511:0] d;
        logic [63:0]  k;
        logic         last;
        for (int i = 0; i < len; i++) begin
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
            k    = {$urandom(), $urandom()};
            last = (i == len - 1);
            si_tvalid = 1'b1;
            si_tdata  = d;
            si_tkeep  = k;
            si_tlast  = last;
            si_tuser  = last ? err : 1'($urandom_range(0, 1));
            if (chk_sf && last) begin
                check("store_fwd_empty", beat_t'(frame_q_empty), beat_t'(1'b1));
            end
            tick();
            fr.push_back({last, k, d});
        end
        si_tvalid = 1'b0;
        si_tlast  = 1'b0;
        si_tuser  = 1'b0;
        if (exp_commit) begin
            foreach (fr[i]) sb_q.push_back(fr[i]);
            exp_frame++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic drain(input string name);
        beat_t e;
        while (sb_q.size() > 0) begin
            if (frame_q_empty) begin
                check({name, "_data_avail"}, beat_t'(frame_q_empty), beat_t'(1'b0));
                sb_q.delete();
                break;
            end
            frame_q_read = 1'b1;
            tick();
            frame_q_read = 1'b0;
            e = sb_q.pop_front();
            last_exp = e;
            check(name, frame_q_dout, e);
            tick();
            check({name, "_hold"}, frame_q_dout, e);
        end
        check({name, "_empty_after"}, beat_t'(frame_q_empty), beat_t'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{len: 3,  err: 1'b0, commit: 1'b1};
        vecs[1] = '{len: 4,  err: 1'b1, commit: 1'b0};
        vecs[2] = '{len: 10, err: 1'b0, commit: 1'b1};
        vecs[3] = '{len: 10, err: 1'b0, commit: 1'b1};
        vecs[4] = '{len: 1,  err: 1'b0, commit: 1'b1};
        vecs[5] = '{len: 1,  err: 1'b1, commit: 1'b0};
        vecs[6] = '{len: 16, err: 1'b0, commit: 1'b1};
        vecs[7] = '{len: 17, err: 1'b0, commit: 1'b0};

        rst          = 1'b1;
        si_tvalid    = 1'b0;
        si_tdata     = '0;
        si_tkeep     = '0;
        si_tlast     = 1'b0;
        si_tuser     = 1'b0;
        frame_q_read = 1'b0;
        last_exp     = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Table: reader drains after every frame; vecs[3] crosses the address wrap.
        foreach (vecs[v]) begin
            send_frame(vecs[v].len, vecs[v].err, vecs[v].commit, 1'b1);
            check("empty_after_tlast", beat_t'(frame_q_empty), beat_t'(!vecs[v].commit));
            check_counts("vec");
            drain("vec_read");
        end

        // Reader stalled: overlong frame enters DROP, following short frame commits.
        send_frame(20, 1'b0, 1'b0, 1'b0);
        send_frame(2, 1'b0, 1'b1, 1'b0);
        check_counts("overlong");
        drain("overlong_read");

        // Committed data occupies the buffer, so the second frame overflows mid-frame.
        send_frame(10, 1'b0, 1'b1, 1'b0);
        send_frame(10, 1'b0, 1'b0, 1'b0);
        check_counts("stalled_overflow");
        drain("stalled_overflow_read");

        // Read request while empty is ignored.
        frame_q_read = 1'b1;
        tick();
        frame_q_read = 1'b0;
        check("empty_read_dout", frame_q_dout, last_exp);
        check("empty_read_empty", beat_t'(frame_q_empty), beat_t'(1'b1));
        send_frame(2, 1'b0, 1'b1, 1'b1);
        drain("after_empty_read");

        // Reset with committed data buffered and a frame in flight.
        send_frame(3, 1'b0, 1'b1, 1'b0);
        si_tvalid = 1'b1;
        si_tdata  = {16{32'hdead_beef}};
        si_tkeep  = '1;
        si_tlast  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_frame_reset");
        rst       = 1'b0;
        si_tvalid = 1'b0;
        sb_q.delete();
        exp_drop  = 0;
        exp_frame = 0;
        tick();
        send_frame(2, 1'b0, 1'b1, 1'b1);
        check_counts("post_reset");
        drain("post_reset_read");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
